// File: rtl/column_writer.sv
// Purpose: clamps a raw wall descriptor and emits it as two 16-bit write beats to the VGA column decoder.
// Latency: beat1 one cycle after accept (plus any residual gap), beat2 BEAT_GAP+1 cycles after beat1.
// Backpressure: none downstream; in_ready drops while a column is in flight and the next descriptor is taken on the beat2 cycle.
module column_writer #(
    parameter int SCREEN_H = 480,
    parameter int NUM_COLS = 640,
    parameter int BEAT_GAP = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] in_height,
    input  logic        in_wall_dir,
    input  logic [2:0]  in_tex_type,
    input  logic [5:0]  in_tex_offset,
    output logic        chipselect,
    output logic        write,
    output logic [15:0] writedata,
    output logic [9:0]  col_count,
    output logic        frame_done
);

    typedef enum logic [1:0] {S_IDLE, S_B1, S_B2} state_t;

    localparam logic [10:0] SCREEN_H11 = 11'(SCREEN_H);
    localparam logic [8:0]  SCREEN_H9  = 9'(SCREEN_H);
    localparam logic [9:0]  LAST_COL   = 10'(NUM_COLS - 1);
    localparam logic [3:0]  GAP_RELOAD = 4'(BEAT_GAP);

    state_t      state;
    logic [3:0]  gap_cnt;
    logic [15:0] beat1;
    logic [15:0] beat2;
    logic [8:0]  h_clamp;
    logic [8:0]  top;
    logic        issue;
    logic        accept;

    // A beat goes out whenever a column is in flight and the inter-beat gap has drained.
    assign issue    = (state != S_IDLE) && (gap_cnt == 4'd0);
    assign in_ready = (state == S_IDLE) || ((state == S_B2) && (gap_cnt == 4'd0));
    assign accept   = in_valid && in_ready;

    // Outputs decode registered state only, so nothing from in_* reaches the decoder port combinationally.
    assign chipselect = issue;
    assign write      = issue;
    assign writedata  = issue ? ((state == S_B1) ? beat1 : beat2) : 16'd0;
    assign frame_done = issue && (state == S_B2) && (col_count == LAST_COL);

    // Height clamp to 1..SCREEN_H and vertical centring; odd differences truncate.
    always_comb begin
        h_clamp = in_height[8:0];
        if (in_height == 11'd0) begin
            h_clamp = 9'd1;
        end else if (in_height > SCREEN_H11) begin
            h_clamp = SCREEN_H9;
        end
        top = (SCREEN_H9 - h_clamp) >> 1;
    end

    // Column FSM, gap timer, packed-word capture and frame column counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            gap_cnt   <= 4'd0;
            col_count <= 10'd0;
            beat1     <= 16'd0;
            beat2     <= 16'd0;
        end else begin
            // The gap keeps draining in idle so the minimum spacing after a beat holds across idle periods.
            if (issue) begin
                gap_cnt <= GAP_RELOAD;
            end else if (gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end

            // Safe to overwrite on the beat2 cycle: the old beat2 is on the bus this very cycle.
            if (accept) begin
                beat1 <= {3'b000, top, in_wall_dir, in_tex_type};
                beat2 <= {1'b0, h_clamp, in_tex_offset};
            end

            case (state)
                S_IDLE: begin
                    if (accept) state <= S_B1;
                end
                S_B1: begin
                    if (issue) state <= S_B2;
                end
                S_B2: begin
                    if (issue) begin
                        state     <= accept ? S_B1 : S_IDLE;
                        col_count <= (col_count == LAST_COL) ? 10'd0 : col_count + 10'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_column_writer.sv
// Bench for column_writer: two instances (BEAT_GAP 0 and 3) against a timing/packing reference model.
// Directed literal checks pin the packing and clamp arithmetic; random phases exercise handshake and gaps.
// Every cycle the model's expected beat stream, in_ready, col_count and frame_done are compared.
module tb_column_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld   [2];
    logic        rdy   [2];
    logic [10:0] hgt   [2];
    logic        dir   [2];
    logic [2:0]  tex   [2];
    logic [5:0]  off   [2];
    logic        cs    [2];
    logic        wr    [2];
    logic [15:0] wd    [2];
    logic [9:0]  col   [2];
    logic        fd    [2];

    always #10 clk = ~clk;

    column_writer #(.SCREEN_H(480), .NUM_COLS(640), .BEAT_GAP(0)) dut0 (
        .clk(clk), .reset(rst), .in_valid(vld[0]), .in_ready(rdy[0]), .in_height(hgt[0]),
        .in_wall_dir(dir[0]), .in_tex_type(tex[0]), .in_tex_offset(off[0]),
        .chipselect(cs[0]), .write(wr[0]), .writedata(wd[0]), .col_count(col[0]), .frame_done(fd[0]));

    column_writer #(.SCREEN_H(480), .NUM_COLS(640), .BEAT_GAP(3)) dut1 (
        .clk(clk), .reset(rst), .in_valid(vld[1]), .in_ready(rdy[1]), .in_height(hgt[1]),
        .in_wall_dir(dir[1]), .in_tex_type(tex[1]), .in_tex_offset(off[1]),
        .chipselect(cs[1]), .write(wr[1]), .writedata(wd[1]), .col_count(col[1]), .frame_done(fd[1]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: per instance, a short queue of (cycle, word, is_beat2) scheduled at accept time.
    int          gap_of   [2] = '{0, 3};
    logic [15:0] q_dat    [2][16];
    int          q_t      [2][16];
    bit          q_b2     [2][16];
    int          hd       [2] = '{0, 0};
    int          tl       [2] = '{0, 0};
    int          last_t   [2] = '{-1000, -1000};
    int          mcol     [2] = '{0, 0};
    int          fd_seen  [2] = '{0, 0};
    bit          armed = 1'b0;

    function automatic logic [31:0] model_b1(input int h, input int d, input int t);
        int hh;
        hh = (h == 0) ? 1 : ((h > 480) ? 480 : h);
        return 32'(((480 - hh) / 2) * 16 + d * 8 + t);
    endfunction

    function automatic logic [31:0] model_b2(input int h, input int o);
        int hh;
        hh = (h == 0) ? 1 : ((h > 480) ? 480 : h);
        return 32'(hh * 64 + o);
    endfunction

    // Single compare process: outputs of both instances against the model, every cycle after the first reset.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit   exp_cs;
            bit   exp_rdy;
            bit   exp_fd;
            int   pend;
            int   h;
            int   t1;
            logic [31:0] exp_wd;
            if (armed) begin
                h       = hd[k] & 15;
                pend    = tl[k] - hd[k];
                exp_cs  = (pend > 0) && (q_t[k][h] == cyc);
                exp_rdy = (pend == 0) || ((pend == 1) && q_b2[k][h] && (q_t[k][h] == cyc));
                exp_fd  = exp_cs && q_b2[k][h] && (mcol[k] == 639);
                exp_wd  = exp_cs ? 32'(q_dat[k][h]) : 32'd0;
                chk($sformatf("chipselect%0d", k), 32'(cs[k]), 32'(exp_cs));
                chk($sformatf("write%0d", k), 32'(wr[k]), 32'(exp_cs));
                chk($sformatf("writedata%0d", k), 32'(wd[k]), exp_wd);
                chk($sformatf("in_ready%0d", k), 32'(rdy[k]), 32'(exp_rdy));
                chk($sformatf("col_count%0d", k), 32'(col[k]), 32'(mcol[k]));
                chk($sformatf("frame_done%0d", k), 32'(fd[k]), 32'(exp_fd));
                if (fd[k]) fd_seen[k]++;
                if (exp_cs) begin
                    if (q_b2[k][h]) mcol[k] = (mcol[k] + 1) % 640;
                    hd[k]++;
                end
                if (vld[k] && rdy[k] && !rst) begin
                    t1 = cyc + 1;
                    if (last_t[k] + gap_of[k] + 1 > t1) t1 = last_t[k] + gap_of[k] + 1;
                    q_t[k][tl[k] & 15]   = t1;
                    q_dat[k][tl[k] & 15] = 16'(model_b1(int'(hgt[k]), int'(dir[k]), int'(tex[k])));
                    q_b2[k][tl[k] & 15]  = 1'b0;
                    tl[k]++;
                    q_t[k][tl[k] & 15]   = t1 + gap_of[k] + 1;
                    q_dat[k][tl[k] & 15] = 16'(model_b2(int'(hgt[k]), int'(off[k])));
                    q_b2[k][tl[k] & 15]  = 1'b1;
                    tl[k]++;
                    last_t[k] = t1 + gap_of[k] + 1;
                end
            end
            if (rst) begin
                hd[k]     = 0;
                tl[k]     = 0;
                mcol[k]   = 0;
                last_t[k] = -1000;
            end
        end
        if (rst) armed = 1'b1;
    end

    task automatic rand_fields(input int k);
        case ($urandom_range(0, 7))
            0:       hgt[k] = 11'd0;
            1:       hgt[k] = 11'd480;
            2:       hgt[k] = 11'd481;
            3:       hgt[k] = 11'd1;
            default: hgt[k] = 11'($urandom_range(0, 2047));
        endcase
        dir[k] = 1'($urandom_range(0, 1));
        tex[k] = 3'($urandom_range(0, 7));
        off[k] = 6'($urandom_range(0, 63));
    endtask

    // Random driver: valid/ready-correct, fields held until accepted.
    task automatic run_rand(input int ncyc, input int pct0, input int pct1);
        bit took [2];
        int pct;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) took[k] = vld[k] && rdy[k];
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                pct = (k == 0) ? pct0 : pct1;
                if (took[k] || !vld[k]) begin
                    vld[k] = ($urandom_range(0, 99) < pct);
                    rand_fields(k);
                end
            end
        end
    endtask

    // One descriptor on instance 0 (idle, no gap) with literal beat expectations.
    task automatic send_check(input logic [10:0] h, input logic d, input logic [2:0] t,
                              input logic [5:0] o, input logic [15:0] e1, input logic [15:0] e2,
                              input bit rst_after_b1, input string name);
        @(posedge clk);
        #1;
        vld[0] = 1'b1; hgt[0] = h; dir[0] = d; tex[0] = t; off[0] = o;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        if (rst_after_b1) rst = 1'b1;
        @(negedge clk);
        chk({name, "_b1_cs"}, 32'(cs[0]), 32'd1);
        chk({name, "_b1"}, 32'(wd[0]), 32'(e1));
        if (rst_after_b1) begin
            @(posedge clk);
            #1;
            rst = 1'b0;
            @(negedge clk);
            chk({name, "_rst_cs"}, 32'(cs[0]), 32'd0);
            chk({name, "_rst_wd"}, 32'(wd[0]), 32'd0);
            chk({name, "_rst_col"}, 32'(col[0]), 32'd0);
        end else begin
            @(negedge clk);
            chk({name, "_b2_cs"}, 32'(cs[0]), 32'd1);
            chk({name, "_b2"}, 32'(wd[0]), 32'(e2));
            chk({name, "_b2_rdy"}, 32'(rdy[0]), 32'd1);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            vld[k] = 1'b0; hgt[k] = 11'd0; dir[k] = 1'b0; tex[k] = 3'd0; off[k] = 6'd0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_cs", 32'(cs[0]), 32'd0);
        chk("rst_wd", 32'(wd[0]), 32'd0);
        chk("rst_rdy", 32'(rdy[0]), 32'd1);
        chk("rst_col", 32'(col[0]), 32'd0);
        chk("rst_fd", 32'(fd[0]), 32'd0);

        // Basic column, then clamp corners.
        send_check(11'd100, 1'b1, 3'd5, 6'd17, 16'h0BED, 16'h1911, 1'b0, "basic");
        @(negedge clk);
        chk("basic_col", 32'(col[0]), 32'd1);
        send_check(11'd0,    1'b0, 3'd0, 6'd0,  16'h0EF0, 16'h0040, 1'b0, "h0");
        send_check(11'd480,  1'b1, 3'd7, 6'd63, 16'h000F, 16'h783F, 1'b0, "h480");
        send_check(11'd1500, 1'b0, 3'd2, 6'd5,  16'h0002, 16'h7805, 1'b0, "h1500");
        send_check(11'd481,  1'b1, 3'd0, 6'd0,  16'h0008, 16'h7800, 1'b0, "h481");
        @(negedge clk);
        chk("col_after5", 32'(col[0]), 32'd5);

        // Reset right after beat1: column dropped, next descriptor starts fresh.
        send_check(11'd200, 1'b0, 3'd1, 6'd9, 16'h08C1, 16'h3209, 1'b1, "midrst");
        send_check(11'd200, 1'b0, 3'd1, 6'd9, 16'h08C1, 16'h3209, 1'b0, "fresh");

        // Continuous stream over a frame boundary on both instances.
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fd_seen[0] = 0;
        fd_seen[1] = 0;
        run_rand(1300, 100, 100);
        chk("frame_pulses0", 32'(fd_seen[0]), 32'd1);
        chk("frame_pulses1", 32'(fd_seen[1]), 32'd0);

        // Random valid toggling.
        run_rand(3000, 50, 50);

        // Drain and confirm nothing is left outstanding.
        run_rand(40, 0, 0);
        chk("drain0", 32'(tl[0] - hd[0]), 32'd0);
        chk("drain1", 32'(tl[1] - hd[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
